// File: rtl/cnn_ofm_writer_if.sv
// Pixel-stream and output-memory bus of the cnn ofm writer.
// slave: the writer. master: the conv engine plus the output fm store.
interface cnn_ofm_writer_if #(
  parameter int unsigned Tm_p     = 1,
  parameter int unsigned DATA_W_p = 16,
  parameter int unsigned ADDR_W_p = 4
);
  // Pixel beat stream from the conv engine.
  logic                     valid;
  logic                     ready;
  logic [Tm_p*DATA_W_p-1:0] data;

  // Write port towards the output feature-map memory.
  logic                     mem_we;
  logic                     mem_ready;
  logic [ADDR_W_p-1:0]      mem_addr;
  logic [Tm_p*DATA_W_p-1:0] mem_data;

  modport master (
    output valid, data, mem_ready,
    input  ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  valid, data, mem_ready,
    output ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/cnn_ofm_writer.sv
// Output-side receiver for the cnn conv engine. Accumulates NPASS_p input-channel passes of an
// R_p x C_p tile of Tm_p-lane pixels in a local buffer, then drains the finished tile to the
// output feature-map memory, once per Tm_p-channel tile, for all M_p/Tm_p tiles of a layer.
// Build option: define CNN_OFM_SAT_EN for saturating lane adds (default: wrap modulo 2^DATA_W_p).
module cnn_ofm_writer #(
  parameter int unsigned M_p      = 1,
  parameter int unsigned R_p      = 4,
  parameter int unsigned C_p      = 4,
  parameter int unsigned Tm_p     = 1,
  parameter int unsigned NPASS_p  = 1,
  parameter int unsigned DATA_W_p = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  cnn_ofm_writer_if.slave bus,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned NumPix   = R_p * C_p;
  localparam int unsigned NumTiles = M_p / Tm_p;
  localparam int unsigned NumWords = NumTiles * NumPix;
  localparam int unsigned AddrW    = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned PixW     = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam int unsigned PassW    = (NPASS_p > 1) ? $clog2(NPASS_p) : 1;
  localparam int unsigned TileW    = (NumTiles > 1) ? $clog2(NumTiles) : 1;
  localparam int unsigned BeatW    = Tm_p * DATA_W_p;

  localparam logic [PixW-1:0]  PixLast  = PixW'(NumPix - 1);
  localparam logic [PassW-1:0] PassLast = PassW'(NPASS_p - 1);
  localparam logic [TileW-1:0] TileLast = TileW'(NumTiles - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  state_e             state_q;
  logic [PixW-1:0]    pix_q;
  logic [PassW-1:0]   pass_q;
  logic [TileW-1:0]   mtile_q;
  logic               ready_q;
  logic               mem_we_q;
  logic [AddrW-1:0]   mem_addr_q;
  logic [BeatW-1:0]   mem_data_q;
  logic               busy_q;
  logic               done_q;

  // Partial-sum tile; never reset, pass 0 overwrites every pixel.
  logic [BeatW-1:0]   tile_buf_q [NumPix];

  logic               beat_fire;
  logic               mem_fire;
  logic               pix_last;
  logic               pass_first;
  logic               pass_last;
  logic               tile_last;
  logic [PixW-1:0]    pix_inc;
  logic [BeatW-1:0]   cur_word;
  logic [BeatW-1:0]   acc_word;

  // One lane add; the carry-out bit of the widened sum is the true sign.
  function automatic logic [DATA_W_p-1:0] lane_add(input logic [DATA_W_p-1:0] a,
                                                   input logic [DATA_W_p-1:0] b);
    logic [DATA_W_p:0] sum;
    sum = {a[DATA_W_p-1], a} + {b[DATA_W_p-1], b};
`ifdef CNN_OFM_SAT_EN
    if (sum[DATA_W_p] != sum[DATA_W_p-1]) begin
      return sum[DATA_W_p] ? {1'b1, {(DATA_W_p-1){1'b0}}} : {1'b0, {(DATA_W_p-1){1'b1}}};
    end
`endif
    return sum[DATA_W_p-1:0];
  endfunction

  // Pixel-word address: tile base plus raster pixel index.
  function automatic logic [AddrW-1:0] word_addr(input logic [TileW-1:0] tile,
                                                 input logic [PixW-1:0]  pix);
    return AddrW'(tile * NumPix + pix);
  endfunction

  // ready_q is only ever set in ACCUM and mem_we_q only in DRAIN.
  assign beat_fire  = bus.valid & ready_q;
  assign mem_fire   = mem_we_q & bus.mem_ready;
  assign pix_last   = (pix_q == PixLast);
  assign pass_first = (pass_q == '0);
  assign pass_last  = (pass_q == PassLast);
  assign tile_last  = (mtile_q == TileLast);
  assign pix_inc    = pix_q + 1'b1;
  assign cur_word   = tile_buf_q[pix_q];

  // Per-lane next partial sum for the pixel addressed by the current beat.
  always_comb begin
    acc_word = '0;
    for (int unsigned t = 0; t < Tm_p; t++) begin
      acc_word[t*DATA_W_p +: DATA_W_p] = pass_first ? bus.data[t*DATA_W_p +: DATA_W_p]
          : lane_add(cur_word[t*DATA_W_p +: DATA_W_p], bus.data[t*DATA_W_p +: DATA_W_p]);
    end
  end

  // Buffer update as a single-cycle read-modify-write, so back-to-back beats to the same pixel
  // always see the previous sum.
  always_ff @(posedge clk_i) begin
    if (beat_fire) begin
      tile_buf_q[pix_q] <= acc_word;
    end
  end

  // Control FSM with registered handshake, memory and status outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= StIdle;
      pix_q      <= '0;
      pass_q     <= '0;
      mtile_q    <= '0;
      ready_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StAccum;
            pix_q   <= '0;
            pass_q  <= '0;
            mtile_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        StAccum: begin
          if (beat_fire) begin
            if (!pix_last) begin
              pix_q <= pix_inc;
            end else begin
              pix_q <= '0;
              if (!pass_last) begin
                pass_q <= pass_q + 1'b1;
              end else begin
                // Final beat of the tile: present word 0 next cycle. With a one-pixel tile
                // word 0 is the sum being written right now, so forward it.
                pass_q     <= '0;
                state_q    <= StDrain;
                ready_q    <= 1'b0;
                mem_we_q   <= 1'b1;
                mem_addr_q <= word_addr(mtile_q, '0);
                mem_data_q <= (NumPix == 1) ? acc_word : tile_buf_q[0];
              end
            end
          end
        end

        StDrain: begin
          // Address and data only move on an accepted write, so stalls hold them.
          if (mem_fire) begin
            if (!pix_last) begin
              pix_q      <= pix_inc;
              mem_addr_q <= word_addr(mtile_q, pix_inc);
              mem_data_q <= tile_buf_q[pix_inc];
            end else begin
              pix_q      <= '0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= '0;
              mem_data_q <= '0;
              if (tile_last) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= StAccum;
                mtile_q <= mtile_q + 1'b1;
                ready_q <= 1'b1;
              end
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
          mtile_q <= '0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_cnn_ofm_writer.sv
// Bench for cnn_ofm_writer: instance A uses default parameters, instance B has two tiles
// (M_p=2) and two passes (NPASS_p=2). One shared stimulus set drives whichever instance sel
// picks; the other sees no start and stays idle.
module tb_cnn_ofm_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        valid;
  logic        mem_ready;
  logic        sel;
  logic [15:0] data;

  logic        start_a, start_b;
  logic        busy_a, done_a, busy_b, done_b;

  cnn_ofm_writer_if #(.Tm_p(1), .DATA_W_p(16), .ADDR_W_p(4)) bus_a ();
  cnn_ofm_writer_if #(.Tm_p(1), .DATA_W_p(16), .ADDR_W_p(5)) bus_b ();

  assign start_a         = start & ~sel;
  assign start_b         = start & sel;
  assign bus_a.valid     = valid;
  assign bus_a.data      = data;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.valid     = valid;
  assign bus_b.data      = data;
  assign bus_b.mem_ready = mem_ready;

  cnn_ofm_writer #(
    .M_p(1), .R_p(4), .C_p(4), .Tm_p(1), .NPASS_p(1), .DATA_W_p(16)
  ) dut_a (
    .clk_i   (clk),
    .reset_i (rst_n),
    .start_i (start_a),
    .bus     (bus_a),
    .busy_o  (busy_a),
    .done_o  (done_a)
  );

  cnn_ofm_writer #(
    .M_p(2), .R_p(4), .C_p(4), .Tm_p(1), .NPASS_p(2), .DATA_W_p(16)
  ) dut_b (
    .clk_i   (clk),
    .reset_i (rst_n),
    .start_i (start_b),
    .bus     (bus_b),
    .busy_o  (busy_b),
    .done_o  (done_b)
  );

  logic        o_ready, o_we, o_busy, o_done;
  logic [4:0]  o_addr;
  logic [15:0] o_data;

  assign o_ready = sel ? bus_b.ready : bus_a.ready;
  assign o_we    = sel ? bus_b.mem_we : bus_a.mem_we;
  assign o_addr  = sel ? bus_b.mem_addr : {1'b0, bus_a.mem_addr};
  assign o_data  = sel ? bus_b.mem_data : bus_a.mem_data;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [15:0] beats    [64];
  logic [15:0] exp_data [32];
  logic [15:0] mem_img  [32];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
  } sat_vec_t;

  sat_vec_t sat_tbl [6];

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Reference lane add from the arithmetic rule, using plain integers.
  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = $signed(a) + $signed(b);
`ifdef CNN_OFM_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  // Beat order: tile-major, then pass, then raster pixel. Word address = tile*16 + pixel.
  task automatic build_expected(input int npass, input int ntiles);
    logic [15:0] acc;
    for (int m = 0; m < ntiles; m++) begin
      for (int p = 0; p < 16; p++) begin
        acc = beats[m*npass*16 + p];
        for (int q = 1; q < npass; q++) acc = add16(acc, beats[m*npass*16 + q*16 + p]);
        exp_data[m*16 + p] = acc;
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 1) == 1) beats[i] = 16'($urandom);
      else beats[i] = {($urandom_range(0, 1) == 1) ? 4'h7 : 4'h8, 12'($urandom)};
    end
  endtask

  // Runs one full layer on the selected instance and checks every write, the handshake
  // timing and the done pulse. stall_at >= 0 holds mem_ready low 3 cycles at that address.
  task automatic run_layer(input bit s, input int gap_pct, input int stall_pct,
                           input bit start_noise, input int stall_at);
    int npass, ntiles, tile_beats, nbeats, nwords;
    int bi, wi, cyc, stall_cnt, hold_cnt;
    bit in_drain, expect_we, expect_done, finished;
    npass      = s ? 2 : 1;
    ntiles     = s ? 2 : 1;
    tile_beats = 16 * npass;
    nbeats     = tile_beats * ntiles;
    nwords     = 16 * ntiles;
    bi = 0; wi = 0; cyc = 0; stall_cnt = 0; hold_cnt = 0;
    in_drain = 0; expect_we = 0; expect_done = 0; finished = 0;
    build_expected(npass, ntiles);
    for (int i = 0; i < 32; i++) mem_img[i] = 16'hDEAD;

    @(negedge clk);
    sel = s; start = 1'b1; valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 2000) begin
      if (expect_we) chk("drain_latency", o_we, 1);
      expect_we = 0;
      if (expect_done) begin
        chk("done_pulse", o_done, 1);
        chk("busy_at_done", o_busy, 0);
        finished = 1;
      end else begin
        chk("done_early", o_done, 0);
      end
      if (in_drain) begin
        chk("we_gap", o_we, 1);
        chk("ready_in_drain", o_ready, 0);
      end
      if (!finished) begin
        start     = start_noise && o_busy && ($urandom_range(0, 7) == 0);
        valid     = (bi < nbeats) && ($urandom_range(0, 99) >= gap_pct);
        data      = (bi < nbeats) ? beats[bi] : 16'($urandom);
        mem_ready = ($urandom_range(0, 99) >= stall_pct);
        if (o_we && int'(o_addr) == stall_at) begin
          hold_cnt++;
          if (stall_cnt < 3) begin
            mem_ready = 1'b0;
            stall_cnt++;
          end
        end
        if (valid && o_ready) begin
          bi++;
          if (bi % tile_beats == 0) expect_we = 1;
        end
        if (o_we) begin
          in_drain = 1;
          if (wi < nwords) begin
            chk("addr", o_addr, wi);
            chk("data", o_data, exp_data[wi]);
          end else begin
            chk("extra_write", o_we, 0);
          end
          if (mem_ready) begin
            mem_img[o_addr] = o_data;
            wi++;
            if (wi % 16 == 0) in_drain = 0;
            if (wi == nwords) expect_done = 1;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    valid = 1'b0;
    chk("timeout", finished, 1);
    chk("beats_used", bi, nbeats);
    chk("writes", wi, nwords);
    if (stall_at >= 0) chk("stall_hold", hold_cnt, 4);
    repeat (3) begin
      @(negedge clk);
      chk("idle_we", o_we, 0);
      chk("idle_done", o_done, 0);
      chk("idle_busy", o_busy, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_we"}, o_we, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; mem_ready = 1'b1; sel = 1'b0; data = '0;

    sat_tbl[0] = '{16'h7000, 16'h2000, 16'h7FFF, 16'h9000};
    sat_tbl[1] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF};
    sat_tbl[2] = '{16'h0003, 16'hFFFE, 16'h0001, 16'h0001};
    sat_tbl[3] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h8000};
    sat_tbl[4] = '{16'h8001, 16'h8001, 16'h8000, 16'h0002};
    sat_tbl[5] = '{16'h1234, 16'h0F00, 16'h2134, 16'h2134};

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; chk_reset_outputs("rst_a");
    sel = 1'b1; #1; chk_reset_outputs("rst_b");
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 1'b0;

    // Single tile, single pass, 1..16 back to back.
    for (int i = 0; i < 64; i++) beats[i] = 16'(i + 1);
    run_layer(1'b0, 0, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) chk("t1_word", mem_img[i], i + 1);

    // Memory backpressure at address 5 plus input gaps.
    fill_random();
    run_layer(1'b0, 40, 0, 1'b0, 5);

    // Two passes: 3 + 5 everywhere in tile 0.
    fill_random();
    for (int i = 0; i < 32; i++) beats[i] = (i < 16) ? 16'd3 : 16'd5;
    run_layer(1'b1, 0, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) chk("t2_word", mem_img[i], 8);

    // Second tile carries 100..115 after a zero pass; start_i noise while busy.
    fill_random();
    for (int p = 0; p < 16; p++) begin
      beats[32 + p] = 16'd0;
      beats[48 + p] = 16'(100 + p);
    end
    run_layer(1'b1, 20, 20, 1'b1, -1);
    for (int p = 0; p < 16; p++) chk("t5_word", mem_img[16 + p], 100 + p);

    // Overflow table on pixel 0 of tile 0.
    for (int i = 0; i < 6; i++) begin
      fill_random();
      beats[0]  = sat_tbl[i].a;
      beats[16] = sat_tbl[i].b;
      run_layer(1'b1, 0, 0, 1'b0, -1);
`ifdef CNN_OFM_SAT_EN
      chk("sat_tbl", mem_img[0], sat_tbl[i].exp_sat);
`else
      chk("sat_tbl", mem_img[0], sat_tbl[i].exp_wrap);
`endif
    end

    // Randomized layers on both instances.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_layer(1'(r % 2), $urandom_range(0, 40), $urandom_range(0, 40), 1'b1, -1);
    end

    // Reset after 5 beats, then a clean rerun of the first layer.
    for (int i = 0; i < 64; i++) beats[i] = 16'(i + 1);
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1;
      data  = beats[k];
      @(negedge clk);
    end
    valid = 1'b0;
    chk("pre_rst_busy", o_busy, 1);
    chk("pre_rst_ready", o_ready, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    valid = 1'b1;
    data  = 16'h5555;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_we", o_we, 0);
      chk("rst_hold_ready", o_ready, 0);
    end
    rst_n = 1'b1;
    valid = 1'b0;
    run_layer(1'b0, 0, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) chk("t6_word", mem_img[i], i + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
